// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, header sync constant and loader state.
// The ALU core and the command loader both import this package.
package alu_pkg;

    localparam int unsigned OP_WIDTH     = 4;
    localparam logic [3:0]  SYNC_DEFAULT = 4'hA;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_XOR = 4'h4,
        OP_SHL = 4'h5,
        OP_SHR = 4'h6,
        OP_CMP = 4'h7,
        OP_MIN = 4'h8,
        OP_MAX = 4'h9,
        OP_MUL = 4'hA,
        OP_ROL = 4'hB,
        OP_NOT = 4'hC,
        OP_NEG = 4'hD,
        OP_INC = 4'hE,
        OP_DEC = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_HDR,
        ST_OPA,
        ST_OPB,
        ST_ISSUE
    } ld_state_e;

    // Opcodes 0xC-0xF take only operand A.
    function automatic logic is_unary(input logic [OP_WIDTH-1:0] op);
        return op[OP_WIDTH-1 -: 2] == 2'b11;
    endfunction

endpackage

// File: rtl/alu_cmd_loader_sat_cnt8.sv
// 8-bit event counter: wraps 255->0 by default, sticks at 255 when SATURATE is set.
module sat_cnt8 #(
    parameter bit SATURATE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic [7:0] cnt
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       at_max;

    assign at_max = (cnt_q == 8'hFF);

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !(SATURATE && at_max)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/alu_cmd_loader.sv
// Byte-serial frame assembler: header/A/B bytes in, one {op, A, B} command out over
// valid/ready, plus issued-command and rejected-header counters for debug readout.
module alu_cmd_loader
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OP_W   = OP_WIDTH,
    parameter logic [3:0]  SYNC   = SYNC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [OP_W-1:0]   cmd_op,
    output logic [DATA_W-1:0] cmd_a,
    output logic [DATA_W-1:0] cmd_b,
    output logic              busy,
    output logic              err,
    output logic [7:0]        frame_cnt,
    output logic [7:0]        err_cnt
);

    ld_state_e         state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              err_q, err_d;

    logic byte_fire;
    logic cmd_fire;
    logic sync_ok;

    // A byte offered during flush is dropped even though in_ready may be high.
    assign byte_fire = in_valid && in_ready && !flush;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign sync_ok   = (in_data[DATA_W-1 -: 4] == SYNC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_HDR;
        end else begin
            unique case (state_q)
                ST_HDR:   if (byte_fire && sync_ok) state_d = ST_OPA;
                ST_OPA:   if (byte_fire) state_d = is_unary(op_q) ? ST_ISSUE : ST_OPB;
                ST_OPB:   if (byte_fire) state_d = ST_ISSUE;
                ST_ISSUE: if (cmd_fire)  state_d = ST_HDR;
                default:  state_d = ST_HDR;
            endcase
        end
    end

    // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        in_ready  = 1'b0;
        cmd_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            ST_HDR:   in_ready  = 1'b1;
            ST_OPA,
            ST_OPB:   begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_ISSUE: begin
                cmd_valid = 1'b1;
                busy      = 1'b1;
            end
            default:  in_ready = 1'b0;
        endcase
    end

    // Command fields change only on accepted bytes, so they hold through ISSUE and afterwards.
    always_comb begin
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        err_d = 1'b0;
        if (byte_fire) begin
            unique case (state_q)
                ST_HDR: begin
                    if (sync_ok) op_d = in_data[OP_W-1:0];
                    else         err_d = 1'b1;
                end
                ST_OPA: begin
                    a_d = in_data;
                    if (is_unary(op_q)) b_d = '0;
                end
                ST_OPB:  b_d = in_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            err_q <= 1'b0;
        end else begin
            op_q  <= op_d;
            a_q   <= a_d;
            b_q   <= b_d;
            err_q <= err_d;
        end
    end

    assign cmd_op = op_q;
    assign cmd_a  = a_q;
    assign cmd_b  = b_q;
    assign err    = err_q;

    // A transfer coinciding with flush still counts as issued.
    sat_cnt8 #(.SATURATE(1'b0)) u_frame_cnt (
        .clk (clk),
        .rst (rst),
        .inc (cmd_fire),
        .cnt (frame_cnt)
    );

    sat_cnt8 #(.SATURATE(1'b1)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_d),
        .cnt (err_cnt)
    );

endmodule

// File: tb/tb_alu_cmd_loader.sv
// Directed bench for alu_cmd_loader: inputs change and outputs are sampled on the falling edge.
module tb_alu_cmd_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       busy;
    logic       err;
    logic [7:0] frame_cnt;
    logic [7:0] err_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_cmd_loader dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .busy      (busy),
        .err       (err),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    // One rising edge passes; returns at the following falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic put(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        cmd_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        cmd_ready = 1'b0;
        tick();
        do_reset();
        checks++;
        if ({in_ready, cmd_valid, busy, err} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags got ir/cv/busy/err=%b want 1000", {in_ready, cmd_valid, busy, err});
        end
        checks++;
        if ({cmd_op, cmd_a, cmd_b, frame_cnt, err_cnt} !== 36'h0) begin
            errors++;
            $display("FAIL reset_values got op=%h a=%h b=%h fc=%0d ec=%0d want all 0",
                     cmd_op, cmd_a, cmd_b, frame_cnt, err_cnt);
        end
    endtask

    task automatic test_binary();
        do_reset();
        cmd_ready = 1'b1;
        put(8'hA1);
        checks++;
        if (busy !== 1'b1 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL bin_after_hdr got busy=%b cv=%b want 1 0", busy, cmd_valid);
        end
        put(8'h05);
        checks++;
        if (cmd_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bin_after_a got cv=%b ir=%b want 0 1", cmd_valid, in_ready);
        end
        put(8'h03);
        checks++;
        if (cmd_valid !== 1'b1 || in_ready !== 1'b0 || cmd_op !== 4'h1 || cmd_a !== 8'h05 || cmd_b !== 8'h03) begin
            errors++;
            $display("FAIL bin_issue got cv=%b ir=%b op=%h a=%h b=%h want 1 0 1 05 03",
                     cmd_valid, in_ready, cmd_op, cmd_a, cmd_b);
        end
        tick();
        checks++;
        if (frame_cnt !== 8'd1 || cmd_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bin_done got fc=%0d cv=%b ir=%b busy=%b want 1 0 1 0",
                     frame_cnt, cmd_valid, in_ready, busy);
        end
    endtask

    task automatic test_unary();
        do_reset();
        cmd_ready = 1'b1;
        put(8'hA1);
        put(8'h05);
        put(8'h03);
        tick();
        cmd_ready = 1'b0;
        put(8'hAC);
        put(8'h0F);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_op !== 4'hC || cmd_a !== 8'h0F || cmd_b !== 8'h00) begin
            errors++;
            $display("FAIL unary_issue got cv=%b op=%h a=%h b=%h want 1 c 0f 00",
                     cmd_valid, cmd_op, cmd_a, cmd_b);
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        put(8'h07);
        checks++;
        if (err !== 1'b1 || err_cnt !== 8'd1 || busy !== 1'b0 || frame_cnt !== 8'd2) begin
            errors++;
            $display("FAIL unary_next_hdr got err=%b ec=%0d busy=%b fc=%0d want 1 1 0 2",
                     err, err_cnt, busy, frame_cnt);
        end
    endtask

    task automatic test_bad_header();
        do_reset();
        put(8'h51);
        checks++;
        if (err !== 1'b1 || err_cnt !== 8'd1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bad_hdr got err=%b ec=%0d busy=%b ir=%b want 1 1 0 1", err, err_cnt, busy, in_ready);
        end
        tick();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL bad_hdr_pulse got err=%b want 0", err);
        end
        cmd_ready = 1'b1;
        put(8'hA2);
        put(8'h01);
        put(8'h02);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_op !== 4'h2 || cmd_a !== 8'h01 || cmd_b !== 8'h02 || err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL bad_then_good got cv=%b op=%h a=%h b=%h ec=%0d want 1 2 01 02 1",
                     cmd_valid, cmd_op, cmd_a, cmd_b, err_cnt);
        end
        tick();
        checks++;
        if (frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL bad_then_good_cnt got fc=%0d want 1", frame_cnt);
        end
    endtask

    task automatic test_err_saturate();
        int pulses = 0;
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data = 8'(i) & 8'h7F;
            tick();
            if (err === 1'b1) pulses++;
        end
        in_valid = 1'b0;
        checks++;
        if (pulses != 256) begin
            errors++;
            $display("FAIL err_consecutive got pulses=%0d want 256", pulses);
        end
        checks++;
        if (err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL err_saturate got ec=%0d want 255", err_cnt);
        end
        tick();
        checks++;
        if (err !== 1'b0 || err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL err_idle got err=%b ec=%0d want 0 255", err, err_cnt);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        do_reset();
        put(8'hA5);
        put(8'h11);
        put(8'h22);
        in_valid = 1'b1;
        in_data  = 8'hA7;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cmd_valid !== 1'b1 || in_ready !== 1'b0 || cmd_op !== 4'h5 ||
                cmd_a !== 8'h11 || cmd_b !== 8'h22) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold got %0d unstable cycles want 0", bad);
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== 8'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got cv=%b ir=%b fc=%0d busy=%b want 0 1 1 0",
                     cmd_valid, in_ready, frame_cnt, busy);
        end
    endtask

    task automatic test_flush();
        do_reset();
        put(8'hA1);
        put(8'h05);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_opb got busy=%b cv=%b ir=%b want 0 0 1", busy, cmd_valid, in_ready);
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL flush_drop_byte got busy=%b fc=%0d want 0 0", busy, frame_cnt);
        end
        put(8'hA3);
        put(8'h10);
        put(8'h20);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0 || frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL flush_issue got cv=%b fc=%0d want 0 0", cmd_valid, frame_cnt);
        end
        put(8'hA3);
        put(8'h10);
        put(8'h20);
        flush     = 1'b1;
        cmd_ready = 1'b1;
        tick();
        flush     = 1'b0;
        cmd_ready = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0 || frame_cnt !== 8'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_with_xfer got cv=%b fc=%0d busy=%b want 0 1 0", cmd_valid, frame_cnt, busy);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        put(8'h51);
        cmd_ready = 1'b1;
        put(8'hA1);
        put(8'h05);
        put(8'h03);
        tick();
        put(8'hA6);
        put(8'h07);
        rst   = 1'b1;
        flush = 1'b1;
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        cmd_ready = 1'b0;
        checks++;
        if ({in_ready, cmd_valid, busy, err} !== 4'b1000 ||
            {cmd_op, cmd_a, cmd_b, frame_cnt, err_cnt} !== 36'h0) begin
            errors++;
            $display("FAIL rst_in_opb got ir/cv/busy/err=%b op=%h a=%h b=%h fc=%0d ec=%0d want 1000 and zeros",
                     {in_ready, cmd_valid, busy, err}, cmd_op, cmd_a, cmd_b, frame_cnt, err_cnt);
        end
    endtask

    task automatic test_frame_wrap();
        int bad = 0;
        do_reset();
        cmd_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            put(8'hA4);
            put(8'(i));
            put(~8'(i));
            if (cmd_valid !== 1'b1 || cmd_a !== 8'(i) || cmd_b !== ~8'(i)) bad++;
            tick();
            if (i == 254) begin
                checks++;
                if (frame_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL frame_cnt_255 got fc=%0d want 255", frame_cnt);
                end
            end
        end
        cmd_ready = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wrap_frames got %0d bad frames want 0", bad);
        end
        checks++;
        if (frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL frame_cnt_wrap got fc=%0d want 0", frame_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        do_reset();
        cmd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            put(8'hAC + 8'(k));
            put(8'h40 + 8'(k));
            if (cmd_valid !== 1'b1 || cmd_op !== 4'hC + 4'(k) || cmd_a !== 8'h40 + 8'(k)) bad++;
            tick();
            if (cmd_valid !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== 8'(k + 1)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL unary_3cyc got %0d bad steps want 0", bad);
        end
        put(8'hA0);
        put(8'h01);
        put(8'h02);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_op !== 4'h0 || cmd_b !== 8'h02) begin
            errors++;
            $display("FAIL binary_after_unary got cv=%b op=%h b=%h want 1 0 02", cmd_valid, cmd_op, cmd_b);
        end
        tick();
        cmd_ready = 1'b0;
        checks++;
        if (frame_cnt !== 8'd4 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_count got fc=%0d ir=%b want 4 1", frame_cnt, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_binary();
        test_unary();
        test_bad_header();
        test_err_saturate();
        test_backpressure();
        test_flush();
        test_rst_mid();
        test_frame_wrap();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_loader.md
# alu_cmd_loader

Byte-serial command assembler sitting directly upstream of the ALU core in the TinyTapeout user project. It accepts a 3-byte (or 2-byte for unary ops) frame on the 8-bit dedicated input path and checks the header. It then presents one complete {opcode, A, B} command to the ALU over a valid/ready handshake. It also keeps issued-command and framing-error counters for debug readout on the bidirectional pins.

## Interface
- Parameters:
- `DATA_W`, 8: operand width.
- `OP_W`, 4: opcode width.
- `SYNC`, 4'hA: required header sync nibble.
- Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `flush`  in  1: synchronous abort of partial or pending frame.
- `in_valid`  in  1: byte present on `in_data`.
- `in_data`  in  DATA_W: frame byte.
- `in_ready`  out  1: loader accepts a byte this cycle.
- `cmd_valid`  out  1: command fields valid.
- `cmd_ready`  in  1: ALU accepts command.
- `cmd_op`  out  OP_W: opcode.
- `cmd_a`  out  DATA_W: operand A.
- `cmd_b`  out  DATA_W: operand B.
- `busy`  out  1: frame in progress or pending (state != HDR).
- `err`  out  1: one-cycle pulse on a rejected header byte.
- `frame_cnt`  out  8: issued commands, wraps 255->0.
- `err_cnt`  out  8: rejected headers, saturates at 255.

## Operation
- A byte transfers on a cycle where `in_valid && in_ready`. A command transfers on a cycle where `cmd_valid && cmd_ready`.
- Frame format:
- Byte 0 is the header: [7:4] = SYNC, [3:0] = opcode.
- Byte 1 is A.
- Byte 2 is B. B is omitted for unary opcodes (op[3:2] == 2'b11, i.e. 0xC-0xF), and `cmd_b` is then driven 0.
- States:
- HDR: `in_ready`=1.
  - Accepted byte with good sync: latch op, go to OPA.
  - Accepted byte with bad sync: drop it, pulse `err`, increment `err_cnt`, stay in HDR.
- OPA: `in_ready`=1. Accepted byte: latch A. Go to ISSUE if op is unary, else OPB.
- OPB: `in_ready`=1. Accepted byte: latch B, go to ISSUE.
- ISSUE: `in_ready`=0, `cmd_valid`=1, fields held stable. On `cmd_ready`: increment `frame_cnt`, go to HDR.
- `flush` has highest priority below `rst`. Next state is HDR and the partial/pending command is discarded. Counters keep their values.
  - A byte offered in a flush cycle is dropped, even though `in_ready` may be high.
  - If `flush` and a command transfer coincide in ISSUE, the transfer stands and `frame_cnt` increments.
- Once `cmd_valid` is asserted, it must not deassert without a transfer, except via `flush` or `rst`.
- `cmd_op/a/b` hold their last latched values outside ISSUE.

## Timing
- All outputs registered or decoded from registered state; no combinational path from `cmd_ready` or `in_valid` to any output.
- Reset values:
- state HDR, so `in_ready`=1.
- `cmd_valid`=0, `busy`=0, `err`=0.
- `cmd_op`=0, `cmd_a`=0, `cmd_b`=0.
- `frame_cnt`=0, `err_cnt`=0.
- Latency: `cmd_valid` rises the cycle after the final operand byte is accepted.
- Throughput, with back-to-back bytes and `cmd_ready` held high:
- Binary op: 4 cycles per command.
- Unary op: 3 cycles per command.
- Next header is accepted the cycle after the command transfer.
- `rst` asserted mid-frame or in ISSUE takes effect at the next edge and overrides `flush`.
- `err` is high for exactly one cycle per rejected byte. Consecutive bad headers give consecutive pulses.

## Structure
- Shared package `alu_pkg` holds:
- Opcode enum (OP_W bits).
- `SYNC` default constant.
- `is_unary(op)` function.
- Loader state typedef {HDR, OPA, OPB, ISSUE}.
- The ALU core imports the same opcode enum.
- One natural sub-module: `sat_cnt8`, an 8-bit counter with `inc` and a `SATURATE` parameter. Instantiated twice: wrap for `frame_cnt`, saturate for `err_cnt`.

## Test plan
- Binary frame 0xA1, 0x05, 0x03 with `cmd_ready`=1 -> `cmd_valid` one cycle after 0x03; op=1, A=5, B=3; `frame_cnt`=1.
- Unary frame 0xAC, 0x0F -> ISSUE after 2 bytes; op=0xC, A=0x0F, B=0; the next byte is treated as a header.
- Header 0x51 -> `err` pulses 1 cycle, `err_cnt`=1, state HDR. A following 0xA2, 0x01, 0x02 issues normally. 256 bad headers -> `err_cnt` stays 255.
- `cmd_ready` held 0 for 5 cycles in ISSUE -> `cmd_valid` and fields stable, `in_ready`=0; on `cmd_ready`=1, transfer happens and `in_ready`=1 the next cycle.
- `flush` after byte A -> HDR, no command issued; `flush` coincident with a transfer -> `frame_cnt` increments.
- `rst` in OPB -> all outputs at reset values the next cycle; 256 good frames -> `frame_cnt` wraps to 0.
